// File: rtl/decode38_seq.sv
// Buffered 3-to-8 decoder/sequencer: FIFO of {en,code}, each shown one-hot on y for max(dwell_cfg,1) cycles.
// Latency: push at edge N appears on y after N+1; backpressure: in_ready = !full. Optional `done` via DECODE38_SEQ_DONE_EN.

// Generic synchronous FIFO with fall-through head; ptrs wrap modulo DEPTH (power of two).
// Latency: written entry visible at head one edge after the push.
// Backpressure: writes ignored while full, reads ignored while empty.
module decode38_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    input  logic                   rd_rdy,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wr     = wr_vld && !full;
    assign rd     = rd_rdy && !empty;
    assign rd_dat = mem_q[rd_ptr_q];
    assign cnt    = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

// Decode sequencer: pops FIFO entries and holds each on y for its dwell period, back-to-back when more are queued.
// Latency: one edge from non-empty FIFO to y; entry lasts max(dwell_cfg,1) cycles, dwell_cfg sampled every cycle.
// Backpressure: in_ready is !full only; a same-edge pop does not free a slot for a push.
module decode38_seq #(
    parameter int DEPTH = 4,
    parameter int DW_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_code,
    input  logic                   in_en,
    input  logic [DW_W-1:0]        dwell_cfg,
    output logic [7:0]             y,
    output logic                   out_valid,
`ifdef DECODE38_SEQ_DONE_EN
    output logic                   done,
`endif
    output logic [$clog2(DEPTH):0] fifo_cnt
);
    typedef struct packed {
        logic       en;
        logic [2:0] code;
    } entry_t;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [7:0]      y_q, y_d;
    logic            out_valid_q, out_valid_d;
    logic [DW_W-1:0] last_cnt;
    logic            entry_end;
    logic            pop;
    logic            full, empty;
    entry_t          head;
    entry_t          push_dat;

    assign push_dat = '{en: in_en, code: in_code};

    decode38_seq_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (in_valid),
        .wr_dat (push_dat),
        .rd_rdy (pop),
        .rd_dat (head),
        .cnt    (fifo_cnt),
        .full   (full),
        .empty  (empty)
    );

    assign in_ready = !full;

    // >= rather than == so that shrinking dwell_cfg below the running count ends the entry on the next edge.
    assign last_cnt  = (dwell_cfg == '0) ? '0 : dwell_cfg - DW_W'(1);
    assign entry_end = (dwell_q >= last_cnt);

`ifdef DECODE38_SEQ_DONE_EN
    logic done_q, done_d;
    assign done = done_q;
`endif

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
`ifdef DECODE38_SEQ_DONE_EN
        done_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    y_d         = head.en ? (8'b1 << head.code) : 8'h00;
                    out_valid_d = 1'b1;
                    dwell_d     = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (entry_end) begin
                    dwell_d = '0;
                    if (!empty) begin
                        pop = 1'b1;
                        y_d = head.en ? (8'b1 << head.code) : 8'h00;
                    end else begin
                        y_d         = 8'h00;
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
`ifdef DECODE38_SEQ_DONE_EN
                        done_d      = 1'b1;
`endif
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dwell_q     <= '0;
            y_q         <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef DECODE38_SEQ_DONE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= done_d;
    end
`endif

    assign y         = y_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_decode38_seq.sv
// Bench for decode38_seq: queue-based reference model checked every cycle, directed literal cases, randomized traffic.
module tb_decode38_seq;
    localparam int DEPTH = 4;
    localparam int DW_W  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_code;
    logic            in_en;
    logic [DW_W-1:0] dwell_cfg;
    logic [7:0]      y;
    logic            out_valid;
    logic [2:0]      fifo_cnt;
`ifdef DECODE38_SEQ_DONE_EN
    logic            done;
`endif

    decode38_seq #(.DEPTH(DEPTH), .DW_W(DW_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .dwell_cfg (dwell_cfg),
        .y         (y),
        .out_valid (out_valid),
`ifdef DECODE38_SEQ_DONE_EN
        .done      (done),
`endif
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending {en,code} entries plus the entry on display
    // and how many cycles it has been visible so far.
    logic [3:0] mq[$];
    bit         m_show;
    logic [3:0] m_cur;
    int         m_shown;
    bit         m_done;

    always @(posedge clk or negedge rst_n) begin
        int  lim;
        bit  do_push;
        if (!rst_n) begin
            mq.delete();
            m_show  = 0;
            m_cur   = '0;
            m_shown = 0;
            m_done  = 0;
        end else begin
            lim     = (dwell_cfg == 0) ? 1 : int'(dwell_cfg);
            do_push = in_valid && (mq.size() < DEPTH);
            m_done  = 0;
            if (m_show) begin
                if (m_shown >= lim) begin
                    if (mq.size() > 0) begin
                        m_cur   = mq.pop_front();
                        m_shown = 1;
                    end else begin
                        m_show = 0;
                        m_done = 1;
                    end
                end else begin
                    m_shown++;
                end
            end else if (mq.size() > 0) begin
                m_cur   = mq.pop_front();
                m_show  = 1;
                m_shown = 1;
            end
            if (do_push) mq.push_back({in_en, in_code});
        end
    end

    function automatic logic [31:0] model_y();
        if (m_show && m_cur[3]) return 32'd1 << m_cur[2:0];
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("y", 32'(y), model_y());
            check("out_valid", 32'(out_valid), 32'(m_show));
            check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
            check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
`ifdef DECODE38_SEQ_DONE_EN
            check("done", 32'(done), 32'(m_done));
`endif
        end
    end

    task automatic drain(input int budget);
        bit ok = 0;
        in_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!out_valid && fifo_cnt == 0) begin
                ok = 1;
                break;
            end
        end
        check("drain_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before t=200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq3 [8];
        logic [3:0] ent3 [4];
        int  n;
        bit  seen_full;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        in_en     = 1'b0;
        dwell_cfg = 8'd3;
        #12;
        check("rst_y", 32'(y), 32'h00);
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset, no pushes.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_y", 32'(y), 32'h00);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd1);
            check("idle_fifo_cnt", 32'(fifo_cnt), 32'd0);
        end

        // Single entry, dwell 3, code 5.
        dwell_cfg = 8'd3;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                check("d3_y", 32'(y), 32'h20);
                check("d3_out_valid", 32'(out_valid), 32'd1);
            end
            if (k == 5) begin
                check("d3_end_y", 32'(y), 32'h00);
                check("d3_end_out_valid", 32'(out_valid), 32'd0);
`ifdef DECODE38_SEQ_DONE_EN
                check("d3_done_pulse", 32'(done), 32'd1);
`endif
            end
`ifdef DECODE38_SEQ_DONE_EN
            if (k == 6) check("d3_done_clear", 32'(done), 32'd0);
`endif
            in_valid = (k == 0);
            in_code  = 3'd5;
            in_en    = 1'b1;
        end
        drain(50);

        // Back-to-back entries with a blank, dwell 2.
        dwell_cfg = 8'd2;
        ent3[0] = 4'b1_000; ent3[1] = 4'b1_111; ent3[2] = 4'b0_011; ent3[3] = 4'b1_010;
        seq3[0] = 8'h01; seq3[1] = 8'h01; seq3[2] = 8'h80; seq3[3] = 8'h80;
        seq3[4] = 8'h00; seq3[5] = 8'h00; seq3[6] = 8'h04; seq3[7] = 8'h04;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 9) begin
                check("b2b_y", 32'(y), 32'(seq3[k-2]));
                check("b2b_out_valid", 32'(out_valid), 32'd1);
            end
            if (k == 10) check("b2b_end_out_valid", 32'(out_valid), 32'd0);
            if (k < 4) begin
                in_valid = 1'b1;
                {in_en, in_code} = ent3[k];
            end else begin
                in_valid = 1'b0;
            end
        end
        drain(50);

        // Continuous pushes against a long dwell: FIFO fills and in_ready holds off the producer.
        dwell_cfg = 8'd10;
        n = 0;
        seen_full = 0;
        for (int g = 0; g < 500 && n < 6; g++) begin
            @(negedge clk);
            if (!in_ready) begin
                seen_full = 1;
                check("full_cnt", 32'(fifo_cnt), 32'd4);
            end
            in_valid = 1'b1;
            in_en    = 1'b1;
            in_code  = 3'(n + 1);
            if (in_ready) n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("fill_accepts", 32'(n), 32'd6);
        check("fill_in_ready_fell", 32'(seen_full), 32'd1);
        drain(200);

        // Dwell 0 behaves as 1.
        dwell_cfg = 8'd0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) check("d0_first", 32'(y), 32'h02);
            if (k == 3) check("d0_second", 32'(y), 32'h04);
            if (k == 4) check("d0_end_out_valid", 32'(out_valid), 32'd0);
            in_valid = (k < 2);
            in_en    = 1'b1;
            in_code  = (k == 0) ? 3'd1 : 3'd2;
        end
        drain(50);

        // Asynchronous reset in the middle of HOLD with three entries buffered.
        dwell_cfg = 8'd10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_en    = 1'b1;
            in_code  = 3'(k + 3);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_cnt", 32'(fifo_cnt), 32'd3);
        check("pre_rst_y", 32'(y), 32'h08);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_y", 32'(y), 32'h00);
        check("async_rst_cnt", 32'(fifo_cnt), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("post_rst_y", 32'(y), 32'h00);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
        end

        // Randomized traffic, including dwell changes while an entry is on display.
        for (int r = 0; r < 4; r++) begin
            dwell_cfg = 8'($urandom_range(0, 4));
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                in_valid = ($urandom_range(0, 99) < 60);
                in_code  = 3'($urandom_range(0, 7));
                in_en    = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 19) == 0) dwell_cfg = 8'($urandom_range(0, 5));
            end
            drain(200);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
